// File: rtl/layer_controller_if.sv
// Handshake bundle between a layer controller, its neuron controller and
// the result buffer. The controller takes the slave view; whoever requests
// layers and answers neuron_start (testbench or parent) takes the master view.
interface layer_controller_if #(
  parameter int N_NEURONS = 4,
  parameter int N_INPUTS  = 8
);
  localparam int IDX_W = $clog2(N_NEURONS);
  localparam int WB_W  = $clog2(N_NEURONS * N_INPUTS);

  logic             start;
  logic             neuron_ready;
  logic             neuron_start;
  logic [IDX_W-1:0] neuron_idx;
  logic [WB_W-1:0]  weight_base;
  logic             out_we;
  logic [IDX_W-1:0] out_addr;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output start, neuron_ready,
    input  neuron_start, neuron_idx, weight_base, out_we, out_addr,
           busy, done, error
  );

  modport slave (
    input  start, neuron_ready,
    output neuron_start, neuron_idx, weight_base, out_we, out_addr,
           busy, done, error
  );
endinterface

// File: rtl/layer_controller.sv
// Layer controller: walks neuron_idx through every neuron of a layer,
// launching the neuron controller, waiting for its completion pulse and
// writing each result into the output buffer.
// Optional feature: define LAYER_CTRL_WDT_EN to add a WAIT-state watchdog
// that aborts the layer into ERROR after WDT_CYCLES cycles without ready.
module layer_controller #(
  parameter int N_NEURONS  = 4,
  parameter int N_INPUTS   = 8,
  parameter int WDT_CYCLES = 64
) (
  input logic              clk,
  input logic              rst,
  layer_controller_if.slave bus
);
  localparam int IDX_W = $clog2(N_NEURONS);
  localparam int WB_W  = $clog2(N_NEURONS * N_INPUTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  // Reject parameter sets the sequencing cannot represent.
  if (N_NEURONS < 2 || N_INPUTS < 2 || WDT_CYCLES < 1) begin : g_bad_params
    $error("layer_controller: N_NEURONS and N_INPUTS must be >= 2, WDT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    STORE,
    DONE,
    ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

`ifdef LAYER_CTRL_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             error_q, error_d;

  // Watchdog count and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      wdt_q   <= wdt_d;
      error_q <= error_d;
    end
  end

  assign bus.error = error_q;
`else
  assign bus.error = 1'b0;
`endif

  // State and neuron index registers; reset abandons any layer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state sequencing; start is only looked at in IDLE and ready only in WAIT.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
`ifdef LAYER_CTRL_WDT_EN
    wdt_d   = wdt_q;
    error_d = error_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d   = '0;
`ifdef LAYER_CTRL_WDT_EN
          error_d = 1'b0;
`endif
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
`ifdef LAYER_CTRL_WDT_EN
        wdt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.neuron_ready) begin
          state_d = STORE;
`ifdef LAYER_CTRL_WDT_EN
        end else if (wdt_q == WDT_LAST) begin
          state_d = ERROR;
          error_d = 1'b1;
        end else begin
          wdt_d = wdt_q + WDT_W'(1);
`endif
        end
      end
      STORE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = LAUNCH;
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.neuron_start = (state_q == LAUNCH);
  assign bus.out_we       = (state_q == STORE);
  assign bus.done         = (state_q == DONE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.neuron_idx   = idx_q;
  assign bus.out_addr     = idx_q;
  assign bus.weight_base  = WB_W'(idx_q) * WB_W'(N_INPUTS);
endmodule

// File: tb/tb_layer_controller.sv
// Scoreboard bench for layer_controller: stimulus pushes the expected
// neuron_start / out_we / done events (with cycle, index and weight base)
// into a queue; a monitor pops and compares whenever the DUT raises one.
// Handles both builds (LAYER_CTRL_WDT_EN defined or not).
`timescale 1ns/1ps
module tb_layer_controller;
  localparam int N_NEURONS  = 4;
  localparam int N_INPUTS   = 8;
  localparam int WDT_CYCLES = 64;

  localparam int EV_LAUNCH = 0;
  localparam int EV_STORE  = 1;
  localparam int EV_DONE   = 2;

  typedef struct {
    int kind;
    int cyc;
    int addr;
    int wb;
  } ev_t;

  logic clk = 1'b0;
  logic rst;

  layer_controller_if #(.N_NEURONS(N_NEURONS), .N_INPUTS(N_INPUTS)) bus ();

  layer_controller #(
    .N_NEURONS (N_NEURONS),
    .N_INPUTS  (N_INPUTS),
    .WDT_CYCLES(WDT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  ev_t  exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   base = 0;
  int   ready_mode = 0;   // 0: neuron model answers, 1: ready held high, 2: ready held low
  int   resp_delay = 0;   // extra WAIT cycles the neuron model takes (W = 1 + resp_delay)
  logic resp_ready = 1'b0;

  assign bus.neuron_ready = (ready_mode == 1) || ((ready_mode == 0) && resp_ready);

  // Free-running cycle counter used to timestamp events.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_LAUNCH: return "neuron_start";
      EV_STORE:  return "out_we";
      default:   return "done";
    endcase
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (rel cycle %0d)", name, act, exp, cyc - base);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".neuron_start"}, int'(bus.neuron_start), 0);
    checkOutput({tag, ".out_we"},       int'(bus.out_we), 0);
    checkOutput({tag, ".done"},         int'(bus.done), 0);
    checkOutput({tag, ".busy"},         int'(bus.busy), 0);
    checkOutput({tag, ".error"},        int'(bus.error), 0);
    checkOutput({tag, ".neuron_idx"},   int'(bus.neuron_idx), 0);
    checkOutput({tag, ".out_addr"},     int'(bus.out_addr), 0);
    checkOutput({tag, ".weight_base"},  int'(bus.weight_base), 0);
  endtask

  task automatic pushEv(input int kind, input int rel, input int addr, input int wb);
    ev_t e;
    e.kind = kind;
    e.cyc  = base + rel;
    e.addr = addr;
    e.wb   = wb;
    exp_q.push_back(e);
  endtask

  // Whole layer whose cycle 0 sits at rel cycle 'off', every neuron taking w WAIT cycles.
  task automatic pushLayer(input int off, input int w);
    for (int i = 0; i < N_NEURONS; i++) begin
      int l;
      l = off + 1 + (2 + w) * i;
      pushEv(EV_LAUNCH, l, i, i * N_INPUTS);
      pushEv(EV_STORE, l + w + 1, i, i * N_INPUTS);
    end
    pushEv(EV_DONE, off + 1 + N_NEURONS * (2 + w), 0, 0);
  endtask

  task automatic applyStimulus(input logic s, input int n);
    bus.start = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic compareEv(input int kind, input int addr, input int wb);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("[TB] FAIL unexpected_%s: got event at cycle %0d addr %0d wb %0d, expected none",
               kname(kind), cyc, addr, wb);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.cyc != cyc || e.addr != addr || e.wb != wb) begin
      n_bad++;
      $display("[TB] FAIL event: got %s cyc %0d addr %0d wb %0d, expected %s cyc %0d addr %0d wb %0d",
               kname(kind), cyc, addr, wb, kname(e.kind), e.cyc, e.addr, e.wb);
    end
  endtask

  // Monitor: every DUT output event is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.neuron_start) compareEv(EV_LAUNCH, int'(bus.neuron_idx), int'(bus.weight_base));
      if (bus.out_we)       compareEv(EV_STORE, int'(bus.out_addr), int'(bus.weight_base));
      if (bus.done)         compareEv(EV_DONE, 0, 0);
    end
  end

  // Neuron controller model: answers each neuron_start after resp_delay extra cycles.
  initial begin
    int cnt;
    cnt = -1;
    forever begin
      @(negedge clk);
      if (cnt == 0) begin
        resp_ready = 1'b1;
        cnt = -1;
      end else begin
        resp_ready = 1'b0;
        if (cnt > 0) cnt--;
      end
      if (bus.neuron_start) cnt = resp_delay;
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL time_limit: simulation still running, expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    int r;
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset_held");
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("after_release");
    repeat (2) @(negedge clk);

    // Nominal layer: ready one cycle after each launch, busy for cycles 1..13.
    $display("[TB] layer with W=1");
    ready_mode = 0;
    resp_delay = 0;
    base = cyc;
    pushLayer(0, 1);
    applyStimulus(1'b1, 1);
    bus.start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      checkOutput("busy_window", int'(bus.busy), (k <= 13) ? 1 : 0);
      @(negedge clk);
    end

    // Slower neuron: three WAIT cycles each, done at 1+4*5.
    $display("[TB] layer with W=3");
    resp_delay = 2;
    base = cyc;
    pushLayer(0, 3);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 23);

    // start held through a whole layer with ready stuck high: no restart
    // while busy, second layer only from IDLE at rel cycle 14.
    $display("[TB] start held high, ready stuck high");
    ready_mode = 1;
    base = cyc;
    pushLayer(0, 1);
    pushLayer(14, 1);
    applyStimulus(1'b1, 14);
    checkOutput("busy_in_idle_gap", int'(bus.busy), 0);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 16);
    ready_mode = 0;
    repeat (3) @(negedge clk);

    // Reset while neuron 2 is in WAIT: no store, no done, restart at index 0.
    $display("[TB] reset during WAIT of neuron 2");
    resp_delay = 3;
    base = cyc;
    pushEv(EV_LAUNCH, 1, 0, 0);
    pushEv(EV_STORE, 6, 0, 0);
    pushEv(EV_LAUNCH, 7, 1, N_INPUTS);
    pushEv(EV_STORE, 12, 1, N_INPUTS);
    pushEv(EV_LAUNCH, 13, 2, 2 * N_INPUTS);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 14);
    checkOutput("idx_before_reset", int'(bus.neuron_idx), 2);
    rst = 1'b1;
    #1;
    checkAllZero("reset_mid_wait");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("post_mid_reset");
    repeat (8) @(negedge clk);
    resp_delay = 0;
    base = cyc;
    pushLayer(0, 1);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 15);

    // Withheld ready: watchdog abort (if built in), then ready on the last allowed cycle.
`ifdef LAYER_CTRL_WDT_EN
    $display("[TB] watchdog timeout");
    ready_mode = 2;
    base = cyc;
    pushEv(EV_LAUNCH, 1, 0, 0);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 65);
    checkOutput("busy_in_error", int'(bus.busy), 1);
    @(negedge clk);
    checkOutput("busy_after_error", int'(bus.busy), 0);
    checkOutput("error_set", int'(bus.error), 1);
    applyStimulus(1'b0, 5);
    checkOutput("error_sticky", int'(bus.error), 1);
    $display("[TB] ready on the last watchdog cycle");
    base = cyc;
    pushEv(EV_LAUNCH, 1, 0, 0);
    applyStimulus(1'b1, 1);
    checkOutput("error_cleared", int'(bus.error), 0);
    applyStimulus(1'b0, 64);
    r = 65;
`else
    $display("[TB] ready withheld for 1000 cycles");
    ready_mode = 2;
    base = cyc;
    pushEv(EV_LAUNCH, 1, 0, 0);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 999);
    checkOutput("busy_long_wait", int'(bus.busy), 1);
    checkOutput("error_long_wait", int'(bus.error), 0);
    r = 1000;
`endif
    pushEv(EV_STORE, r + 1, 0, 0);
    for (int i = 1; i < N_NEURONS; i++) begin
      pushEv(EV_LAUNCH, r + 3 * i - 1, i, i * N_INPUTS);
      pushEv(EV_STORE, r + 3 * i + 1, i, i * N_INPUTS);
    end
    pushEv(EV_DONE, r + 3 * N_NEURONS - 1, 0, 0);
    ready_mode = 1;
    applyStimulus(1'b0, 14);
    checkOutput("error_after_resume", int'(bus.error), 0);
    checkOutput("busy_after_resume", int'(bus.busy), 0);
    ready_mode = 0;
    repeat (2) @(negedge clk);

    checkOutput("events_outstanding", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/layer_controller.md
LAYER_CONTROLLER -- requirements
Module: layer_controller

Interface
REQ-001 The block SHALL have parameter N_NEURONS, default 4, meaning neurons in the layer (min 2).
REQ-002 The block SHALL have parameter N_INPUTS, default 8, meaning inputs per neuron (min 2).
REQ-003 The block SHALL have parameter WDT_CYCLES, default 64, meaning maximum WAIT cycles before timeout (used only with LAYER_CTRL_WDT_EN).
REQ-004 The block SHALL have port clk, input, 1 bit, clock.
REQ-005 The block SHALL have port rst, input, 1 bit, reset (asynchronous, active-high).
REQ-006 The block SHALL have port start, input, 1 bit, layer start request.
REQ-007 The block SHALL have port neuron_ready, input, 1 bit, completion pulse from the neuron controller.
REQ-008 The block SHALL have port neuron_start, output, 1 bit, start pulse to the neuron controller.
REQ-009 The block SHALL have port neuron_idx, output, $clog2(N_NEURONS) bits, index of the neuron being computed.
REQ-010 The block SHALL have port weight_base, output, $clog2(N_NEURONS*N_INPUTS) bits, weight-memory base address, equal to neuron_idx*N_INPUTS.
REQ-011 The block SHALL have port out_we, output, 1 bit, result-buffer write enable.
REQ-012 The block SHALL have port out_addr, output, $clog2(N_NEURONS) bits, result-buffer write address.
REQ-013 The block SHALL have ports busy, done and error, all outputs of 1 bit, meaning layer in progress, layer complete pulse, and sticky timeout flag respectively.

Function
REQ-014 The FSM SHALL have states IDLE, LAUNCH, WAIT, STORE, DONE, ERROR, with registered state and combinational outputs decoded from the state.
REQ-015 In IDLE, start=1 SHALL clear neuron_idx to 0, clear error, and go to LAUNCH; otherwise the FSM SHALL stay in IDLE.
REQ-016 In LAUNCH, the block SHALL drive neuron_start=1 for exactly one cycle, then go to WAIT.
REQ-017 In WAIT, neuron_ready=1 SHALL move the FSM to STORE; otherwise the FSM SHALL stay in WAIT (timeout per REQ-027).
REQ-018 In STORE, the block SHALL drive out_we=1 with out_addr=neuron_idx; if neuron_idx==N_NEURONS-1 the FSM SHALL go to DONE, else it SHALL increment neuron_idx and go to LAUNCH.
REQ-019 In DONE, the block SHALL drive done=1 for one cycle, then go to IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 Each neuron SHALL cost 2+W cycles, where W is the number of WAIT cycles including the cycle in which ready is seen (W≥1); done SHALL rise in cycle 1+N_NEURONS*(2+W), with cycle 0 being the cycle in which start is sampled.
REQ-022 start while busy SHALL be ignored.
REQ-023 neuron_ready outside WAIT SHALL be ignored.
REQ-024 neuron_idx SHALL never exceed N_NEURONS-1 and SHALL wrap only via a new start.
REQ-025 weight_base SHALL be derived combinationally from neuron_idx and SHALL be stable from LAUNCH through STORE.

Reset
REQ-026 rst=1 SHALL force IDLE, neuron_idx=0, watchdog=0 and error=0 at any time, including mid-layer; all outputs SHALL be 0 while rst=1 and in the first cycle after release, and an in-flight neuron result SHALL be discarded (no out_we).

Configuration
REQ-027 With LAYER_CTRL_WDT_EN defined, a watchdog counter SHALL clear in LAUNCH and count WAIT cycles; if the WDT_CYCLES-th WAIT cycle has neuron_ready=0, the FSM SHALL go to ERROR, which sets error=1 (sticky until the next accepted start), pulses no done, and returns to IDLE next cycle; ready in that same cycle SHALL win and go to STORE.
REQ-028 Without LAYER_CTRL_WDT_EN, the block SHALL contain no watchdog logic, ERROR SHALL be unreachable, error SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Verification
REQ-029 With N_NEURONS=4 and start pulsed at cycle 0, ready returned one cycle after each neuron_start: neuron_start SHALL fire in cycles 1, 4, 7, 10; out_we SHALL fire in cycles 3, 6, 9, 12 with out_addr 0..3; done SHALL fire in cycle 13; busy SHALL be high in cycles 1-13.
REQ-030 With N_INPUTS=8: weight_base SHALL read 0, 8, 16, 24 during neurons 0-3.
REQ-031 start held high throughout a layer plus a spurious neuron_ready during LAUNCH: no restart and no extra out_we SHALL occur; a second layer SHALL begin only after returning to IDLE.
REQ-032 rst asserted during WAIT of neuron 2: all outputs SHALL drop to 0 immediately, no done SHALL occur, and a following start SHALL restart from neuron_idx=0.
REQ-033 With LAYER_CTRL_WDT_EN defined and WDT_CYCLES=64 and neuron_ready never asserted: ERROR SHALL be entered after 64 WAIT cycles; error SHALL be 1 and remain 1 in IDLE; the next start SHALL clear it. With ready on exactly the 64th WAIT cycle: STORE SHALL be entered and error SHALL stay 0.
REQ-034 Without LAYER_CTRL_WDT_EN and ready withheld for 1000 cycles: the FSM SHALL remain in WAIT and error SHALL stay 0; a later ready SHALL resume normal sequencing.
